// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register between CPU stages. Carries a control
// bundle (masked to zero whenever the stage shows a bubble) and a data bundle,
// with valid/ready flow control, stall hold, flush with a discarded-beat
// counter and an optional second (skid) entry that registers in_ready_o.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Head entry M
  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  // Skid entry S (held at zero when SKID=0)
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  // Saturating discarded-beat counter
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              accept;
  logic              emit;
  logic [1:0]        drop_cnt;
  logic [CNT_W+1:0]  flush_sum;

  // Head entry drives the downstream side; a stall hides it completely.
  always_comb begin
    out_valid_o = m_valid_q & ~stall_i;
    out_ctrl_o  = out_valid_o ? m_ctrl_q : '0;
    out_data_o  = m_data_q;
    occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    flush_cnt_o = flush_cnt_q;
  end

  if (SKID != 0) begin : g_skid_ready
    // Ready depends only on the registered skid state, never on out_ready_i.
    assign in_ready_o = rst_i & ~stall_i & ~s_valid_q;
  end else begin : g_comb_ready
    // Single entry: free now, or about to be freed by this cycle's emit.
    assign in_ready_o = rst_i & ~stall_i & (~m_valid_q | out_ready_i);
  end

  // Handshakes and the number of valid beats a flush this cycle would drop:
  // the head unless it is being emitted, the skid entry, and any new accept.
  always_comb begin
    accept    = in_valid_i & in_ready_o;
    emit      = out_valid_o & out_ready_i;
    drop_cnt  = {1'b0, m_valid_q & ~emit} + {1'b0, s_valid_q} + {1'b0, accept};
    flush_sum = {2'b00, flush_cnt_q} + {{CNT_W{1'b0}}, drop_cnt};
  end

  // Next-state: flush beats stall beats normal flow.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_ctrl_d    = m_ctrl_q;
    m_data_d    = m_data_q;
    s_valid_d   = s_valid_q;
    s_ctrl_d    = s_ctrl_q;
    s_data_d    = s_data_q;
    flush_cnt_d = flush_cnt_q;

    if (flush_i) begin
      // Contents are only invalidated; payload registers keep their values.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if (flush_sum > {2'b00, {CNT_W{1'b1}}}) begin
        flush_cnt_d = {CNT_W{1'b1}};
      end else begin
        flush_cnt_d = flush_sum[CNT_W-1:0];
      end
    end else if (!stall_i) begin
      if (SKID != 0) begin
        if (emit) begin
          if (s_valid_q) begin
            // Skid entry moves up; new beat (if any) takes its place.
            m_valid_d = 1'b1;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = accept;
            if (accept) begin
              s_ctrl_d = in_ctrl_i;
              s_data_d = in_data_i;
            end
          end else begin
            m_valid_d = accept;
            if (accept) begin
              m_ctrl_d = in_ctrl_i;
              m_data_d = in_data_i;
            end
          end
        end else if (accept) begin
          // No emit: fill the head first, the skid entry second.
          if (!m_valid_q) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl_i;
            m_data_d  = in_data_i;
          end else begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl_i;
            s_data_d  = in_data_i;
          end
        end
      end else begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = in_ctrl_i;
          m_data_d  = in_data_i;
        end else if (emit) begin
          m_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      s_valid_q   <= 1'b0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      s_valid_q   <= s_valid_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives one SKID=0 and one SKID=1 instance with the
// same input stream and compares each against a queue model of the stage.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic         out_ready;
  logic         stall;
  logic         flush;

  logic         in_ready_w  [2];
  logic         out_valid_w [2];
  logic [7:0]   out_ctrl_w  [2];
  logic [127:0] out_data_w  [2];
  logic [1:0]   occ_w       [2];
  logic [7:0]   fcnt_w      [2];

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w[0]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid_w[0]), .out_ready_i(out_ready),
    .out_ctrl_o(out_ctrl_w[0]), .out_data_o(out_data_w[0]),
    .stall_i(stall), .flush_i(flush),
    .occupancy_o(occ_w[0]), .flush_cnt_o(fcnt_w[0])
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w[1]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid_w[1]), .out_ready_i(out_ready),
    .out_ctrl_o(out_ctrl_w[1]), .out_data_o(out_data_w[1]),
    .stall_i(stall), .flush_i(flush),
    .occupancy_o(occ_w[1]), .flush_cnt_o(fcnt_w[1])
  );

  // Reference model: an ordered list of held beats per instance (index 0 is
  // the beat presented downstream), the discarded-beat total, and the data
  // last presented at the head position.
  logic [7:0]   mc    [2][4];
  logic [127:0] md    [2][4];
  int           msz   [2];
  int           mcnt  [2];
  logic [127:0] mhead [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s skid=%0d got=%0h want=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [127:0] rdata();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: apply inputs, check both instances mid-cycle, advance model.
  task automatic step(input logic r, input logic v, input logic [7:0] c, input logic [127:0] d,
                      input logic ordy, input logic st, input logic fl);
    logic exp_rdy, exp_vld, acc, emt;
    int   tot;
    rst_n = r; in_valid = v; in_ctrl = c; in_data = d;
    out_ready = ordy; stall = st; flush = fl;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      // SKID=1 keeps a free slot as long as fewer than two beats are held;
      // SKID=0 can take a beat when empty or when the held one leaves now.
      exp_rdy = r && !st && ((k == 1) ? (msz[k] < 2) : (msz[k] == 0 || ordy));
      exp_vld = (msz[k] > 0) && !st;
      chk("in_ready",  k, 128'(in_ready_w[k]),  128'(exp_rdy));
      chk("out_valid", k, 128'(out_valid_w[k]), 128'(exp_vld));
      chk("out_ctrl",  k, 128'(out_ctrl_w[k]),  128'(exp_vld ? mc[k][0] : 8'h00));
      chk("out_data",  k, out_data_w[k],        (msz[k] > 0) ? md[k][0] : mhead[k]);
      chk("occupancy", k, 128'(occ_w[k]),       128'(msz[k]));
      chk("flush_cnt", k, 128'(fcnt_w[k]),      128'(mcnt[k]));

      acc = v && exp_rdy;
      emt = exp_vld && ordy;
      if (!r) begin
        msz[k] = 0; mcnt[k] = 0; mhead[k] = '0;
      end else if (fl) begin
        tot = mcnt[k] + msz[k] - (emt ? 1 : 0) + (acc ? 1 : 0);
        mcnt[k] = (tot > 255) ? 255 : tot;
        msz[k] = 0;
      end else if (!st) begin
        if (emt) begin
          for (int j = 0; j < 3; j++) begin
            mc[k][j] = mc[k][j+1];
            md[k][j] = md[k][j+1];
          end
          msz[k]--;
        end
        if (acc) begin
          mc[k][msz[k]] = c;
          md[k][msz[k]] = d;
          msz[k]++;
        end
      end
      if (msz[k] > 0) mhead[k] = md[k][0];
    end
    $display("step r=%0b v=%0b c=%02h ordy=%0b st=%0b fl=%0b occ0=%0d occ1=%0d cnt0=%0d cnt1=%0d",
             r, v, c, ordy, st, fl, msz[0], msz[1], mcnt[0], mcnt[1]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r, v, o, s, f;
    for (int k = 0; k < 2; k++) begin
      msz[k] = 0; mcnt[k] = 0; mhead[k] = '0;
      for (int j = 0; j < 4; j++) begin mc[k][j] = '0; md[k][j] = '0; end
    end
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with upstream offering a beat, then released.
    step(1'b0, 1'b1, 8'h77, rdata(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h78, rdata(), 1'b1, 1'b0, 1'b0);

    // Sustained stream with downstream always ready.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i + 1), 128'(i), 1'b1, 1'b0, 1'b0);
    // Back-pressure for three cycles mid-stream, then release and drain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h20 + i), 128'(32 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 128'(64 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 128'(0), 1'b1, 1'b0, 1'b0);

    // Stall with 0xA5 held at the head.
    step(1'b1, 1'b1, 8'hA5, 128'hA5A5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h5A, rdata(), 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 128'(0), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 128'(0), 1'b1, 1'b0, 1'b0);

    // Flush with the stage full and upstream offering a beat.
    step(1'b1, 1'b1, 8'h31, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h32, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h33, rdata(), 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, rdata(), 1'b0, 1'b0, 1'b0);
    // Flush with one beat held, a new accept and an emit in the same cycle.
    step(1'b1, 1'b1, 8'h34, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h35, rdata(), 1'b1, 1'b0, 1'b1);
    // Flush together with stall.
    step(1'b1, 1'b1, 8'h36, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h37, rdata(), 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, rdata(), 1'b1, 1'b0, 1'b0);

    // Repeated flushes drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 8'($urandom()), rdata(), 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'($urandom()), rdata(), 1'b0, 1'b0, 1'b1);
    end

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      step(r, v, 8'($urandom()), rdata(), o, s, f);
    end

    // Reset mid-stream with the stage full.
    step(1'b1, 1'b1, 8'h61, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h62, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h63, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h64, rdata(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h65, rdata(), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, rdata(), 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
